vesa_sync_receiver: RTL and testbench

Receive-side counterpart of the 1280x1024 VESA timing generator. It samples an incoming active-low `Hsyncb`/`Vsyncb` pair in the pixel-clock domain and measures line length, hsync pulse width and frame height. It locks once the timing has been stable for a programmable number of frames, then regenerates active-region pixel coordinates and a data-enable. Downstream capture and overlay logic use it to address pixels of an external video stream.

---
 rtl/vesa_sync_receiver_if.sv | 25 ++
 rtl/vesa_sync_receiver.sv | 185 ++++++++++++++++++
 tb/tb_vesa_sync_receiver.sv | 362 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vesa_sync_receiver_if.sv
// Sync inputs and measurement/coordinate outputs of the VESA sync receiver.
// The master drives the syncs; the receiver is the slave.
interface vesa_sync_receiver_if;
  logic        Hsyncb;
  logic        Vsyncb;
  logic [10:0] x;
  logic [10:0] y;
  logic        de;
  logic        frame_start;
  logic [10:0] htotal;
  logic [10:0] hsync_width;
  logic [10:0] vtotal;
  logic        locked;
  logic        error;

  modport master (
    output Hsyncb, Vsyncb,
    input  x, y, de, frame_start, htotal, hsync_width, vtotal, locked, error
  );

  modport slave (
    input  Hsyncb, Vsyncb,
    output x, y, de, frame_start, htotal, hsync_width, vtotal, locked, error
  );
endinterface

// File: rtl/vesa_sync_receiver.sv
// Measures an incoming active-low H/V sync pair, locks after LOCK_FRAMES
// consistent frames and regenerates active-region coordinates and data-enable.
module vesa_sync_receiver #(
  parameter int HLEN        = 1280,
  parameter int VHEIGHT     = 1024,
  parameter int HSTART      = 356,
  parameter int VSTART      = 40,
  parameter int LOCK_FRAMES = 2
) (
  input  logic clk,
  input  logic reset,
  vesa_sync_receiver_if.slave vif
);

  localparam logic [10:0] CMAX      = 11'h7FF;
  localparam logic [10:0] H_FIRST   = 11'(HSTART);
  localparam logic [10:0] H_LAST    = 11'(HSTART + HLEN - 1);
  localparam logic [10:0] V_FIRST   = 11'(VSTART);
  localparam logic [10:0] V_LAST    = 11'(VSTART + VHEIGHT - 1);
  localparam logic [3:0]  MATCH_TGT = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

  state_t      state_q, state_d;
  logic        hs_r_q, hs_p_q, vs_r_q, vs_p_q;
  logic [10:0] hcnt_q, hlow_q, lcnt_q;
  logic [10:0] htotal_q, hsync_width_q, vtotal_q;
  logic [3:0]  match_q, match_d;
  logic        hvalid_q, hvalid_d;
  logic        vvalid_q, vvalid_d;
  logic        bad_q, bad_d;
  logic        locked_q, error_q, de_q, frame_start_q;
  logic [10:0] x_q, y_q;

  logic        h_edge, v_edge, hs_rise;
  logic [10:0] hcnt_inc;
  logic        h_mismatch, v_mismatch, saturated, frame_bad;
  logic        error_d, de_d, frame_start_d;

  assign h_edge     = hs_p_q & ~hs_r_q;
  assign v_edge     = vs_p_q & ~vs_r_q;
  assign hs_rise    = ~hs_p_q & hs_r_q;
  assign hcnt_inc   = hcnt_q + 11'd1;
  assign h_mismatch = h_edge & hvalid_q & (hcnt_inc != htotal_q);
  // vvalid guards against comparing the first full frame with a partial one
  assign v_mismatch = v_edge & vvalid_q & (lcnt_q != vtotal_q);
  assign saturated  = (hcnt_q == CMAX) | (lcnt_q == CMAX);
  assign frame_bad  = bad_q | h_mismatch | v_mismatch | saturated;

  always_comb begin
    state_d  = state_q;
    match_d  = match_q;
    hvalid_d = hvalid_q;
    vvalid_d = vvalid_q;
    bad_d    = bad_q;
    case (state_q)
      SEARCH: begin
        if (v_edge) begin
          state_d  = TRACK;
          match_d  = 4'd0;
          hvalid_d = 1'b0;
          vvalid_d = 1'b0;
          bad_d    = 1'b0;
        end
      end
      TRACK: begin
        if (h_edge) hvalid_d = 1'b1;
        if (v_edge) begin
          bad_d    = 1'b0;
          vvalid_d = 1'b1;
          if (frame_bad) begin
            match_d = 4'd0;
          end else begin
            match_d = match_q + 4'd1;
            if (match_d == MATCH_TGT) state_d = LOCKED;
          end
        end else if (h_mismatch || saturated) begin
          bad_d = 1'b1;
        end
      end
      LOCKED: begin
        if (h_mismatch || v_mismatch || saturated) begin
          state_d  = SEARCH;
          match_d  = 4'd0;
          hvalid_d = 1'b0;
          vvalid_d = 1'b0;
          bad_d    = 1'b0;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  assign error_d       = (state_q == LOCKED) && (state_d == SEARCH);
  assign de_d          = (state_d == LOCKED) &&
                         (hcnt_q >= H_FIRST) && (hcnt_q <= H_LAST) &&
                         (lcnt_q >= V_FIRST) && (lcnt_q <= V_LAST);
  assign frame_start_d = de_d && (hcnt_q == H_FIRST) && (lcnt_q == V_FIRST);

  // Sync history resets high so release of reset never looks like a falling edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_r_q <= 1'b1;
      hs_p_q <= 1'b1;
      vs_r_q <= 1'b1;
      vs_p_q <= 1'b1;
    end else begin
      hs_r_q <= vif.Hsyncb;
      hs_p_q <= hs_r_q;
      vs_r_q <= vif.Vsyncb;
      vs_p_q <= vs_r_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcnt_q        <= '0;
      hlow_q        <= '0;
      lcnt_q        <= '0;
      htotal_q      <= '0;
      hsync_width_q <= '0;
      vtotal_q      <= '0;
    end else begin
      if (h_edge) begin
        htotal_q <= hcnt_inc;
        hcnt_q   <= '0;
      end else if (hcnt_q != CMAX) begin
        hcnt_q <= hcnt_inc;
      end
      if (hs_rise) begin
        hsync_width_q <= hlow_q;
        hlow_q        <= '0;
      end else if (!hs_r_q && hlow_q != CMAX) begin
        hlow_q <= hlow_q + 11'd1;
      end
      if (v_edge) begin
        vtotal_q <= lcnt_q;
        lcnt_q   <= '0;
      end else if (h_edge && lcnt_q != CMAX) begin
        lcnt_q <= lcnt_q + 11'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= SEARCH;
      match_q       <= '0;
      hvalid_q      <= 1'b0;
      vvalid_q      <= 1'b0;
      bad_q         <= 1'b0;
      locked_q      <= 1'b0;
      error_q       <= 1'b0;
      de_q          <= 1'b0;
      frame_start_q <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
    end else begin
      state_q       <= state_d;
      match_q       <= match_d;
      hvalid_q      <= hvalid_d;
      vvalid_q      <= vvalid_d;
      bad_q         <= bad_d;
      locked_q      <= (state_d == LOCKED);
      error_q       <= error_d;
      de_q          <= de_d;
      frame_start_q <= frame_start_d;
      if (de_d) begin
        x_q <= hcnt_q - H_FIRST;
        y_q <= lcnt_q - V_FIRST;
      end
    end
  end

  assign vif.x           = x_q;
  assign vif.y           = y_q;
  assign vif.de          = de_q;
  assign vif.frame_start = frame_start_q;
  assign vif.htotal      = htotal_q;
  assign vif.hsync_width = hsync_width_q;
  assign vif.vtotal      = vtotal_q;
  assign vif.locked      = locked_q;
  assign vif.error       = error_q;

endmodule

// File: tb/tb_vesa_sync_receiver.sv
// Bench for vesa_sync_receiver on a scaled-down raster (40x20 total, 24x14 active);
// active pixels are queued as the stream is generated and popped as de appears.
module tb_vesa_sync_receiver;
  localparam int HLEN = 24, VHEIGHT = 14, HSTART = 8, VSTART = 3, LOCK_FRAMES = 2;
  localparam int HT = 40, HSW = 5, VT = 20, VOFF = 20;

  logic clk = 1'b0;
  logic reset = 1'b1;
  vesa_sync_receiver_if vif();

  vesa_sync_receiver #(
    .HLEN(HLEN), .VHEIGHT(VHEIGHT), .HSTART(HSTART), .VSTART(VSTART),
    .LOCK_FRAMES(LOCK_FRAMES)
  ) dut (
    .clk(clk),
    .reset(reset),
    .vif(vif)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [10:0] x; logic [10:0] y;} pix_t;
  pix_t exp_q[$];
  pix_t mon_p;
  pix_t push_p;

  int n_cmp = 0, n_bad = 0;
  int gh, gl, ht_cur, vt_cur, vfalls, glitch_gl;
  bit expect_lock, tall_next, tall_active, height_bad;
  int de_cnt = 0, fs_cnt = 0, err_cnt = 0;
  logic err_prev = 1'b0;

  // One pixel clock of generated stream, driven on the falling edge
  task automatic step();
    @(negedge clk);
    vif.Hsyncb = (gh < HSW) ? 1'b0 : 1'b1;
    vif.Vsyncb = ((gl == 0 && gh >= VOFF) || gl == 1 || (gl == 2 && gh < VOFF)) ? 1'b0 : 1'b1;
    if (gl == 0 && gh == VOFF) begin
      if (expect_lock && height_bad) begin
        expect_lock = 1'b0;
        vfalls = 0;
      end else if (!expect_lock) begin
        vfalls++;
        if (vfalls == LOCK_FRAMES + 1) expect_lock = 1'b1;
      end
      height_bad = 1'b0;
    end
    if (gh == 0 && expect_lock && gl >= VSTART && gl < VSTART + VHEIGHT) begin
      for (int i = 0; i < HLEN; i++) begin
        push_p.x = 11'(i);
        push_p.y = 11'(gl - VSTART);
        exp_q.push_back(push_p);
      end
    end
    gh++;
    if (gh == ht_cur) begin
      gh = 0;
      if (gl == glitch_gl) begin
        expect_lock = 1'b0;
        vfalls = 0;
        glitch_gl = -1;
      end
      gl++;
      if (gl == vt_cur) begin
        gl = 0;
        if (tall_active) begin
          height_bad = 1'b1;
          tall_active = 1'b0;
        end
        if (tall_next) begin
          vt_cur = VT + 1;
          tall_next = 1'b0;
          tall_active = 1'b1;
        end else begin
          vt_cur = VT;
        end
      end
      ht_cur = (gl == glitch_gl) ? HT - 1 : HT;
    end
  endtask

  task automatic run_steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_to_pos(input int l, input int h, output bit ok);
    int guard = 0;
    while (!(gl == l && gh == h) && guard < 3 * HT * (VT + 1)) begin
      step();
      guard++;
    end
    ok = (gl == l && gh == h);
  endtask

  task automatic run_to_vfall(input int target, output bit ok);
    int guard = 0;
    while (vfalls < target && guard < 6 * HT * (VT + 1)) begin
      step();
      guard++;
    end
    ok = (vfalls >= target);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (vif.error) begin
        err_cnt++;
        n_cmp++;
        if (err_prev) begin
          n_bad++;
          $display("FAIL error_width error high on consecutive cycles, required single-cycle pulse");
        end
      end
      err_prev = vif.error;
      if (vif.de) begin
        de_cnt++;
        if (vif.frame_start) fs_cnt++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL pixel_unexpected got x=%0d y=%0d, required de=0", vif.x, vif.y);
        end else begin
          mon_p = exp_q.pop_front();
          if (vif.x !== mon_p.x || vif.y !== mon_p.y ||
              vif.frame_start !== (mon_p.x == 11'd0 && mon_p.y == 11'd0)) begin
            n_bad++;
            $display("FAIL pixel got x=%0d y=%0d fs=%0b, required x=%0d y=%0d fs=%0b",
                     vif.x, vif.y, vif.frame_start, mon_p.x, mon_p.y,
                     (mon_p.x == 11'd0 && mon_p.y == 11'd0));
          end
        end
      end else if (vif.frame_start) begin
        n_cmp++;
        n_bad++;
        $display("FAIL frame_start_no_de got frame_start=1 with de=0, required 0");
      end
    end else begin
      err_prev = 1'b0;
    end
  end

  task automatic test_reset();
    logic [59:0] outs;
    gh = 0; gl = 10; ht_cur = HT; vt_cur = VT; vfalls = 0; glitch_gl = -1;
    expect_lock = 0; tall_next = 0; tall_active = 0; height_bad = 0;
    vif.Hsyncb = 1'b1;
    vif.Vsyncb = 1'b1;
    run_steps(5);
    outs = {vif.x, vif.y, vif.htotal, vif.hsync_width, vif.vtotal,
            vif.de, vif.frame_start, vif.locked, vif.error};
    n_cmp++;
    if (outs !== 60'd0) begin
      n_bad++;
      $display("FAIL reset_outputs got %h, required 0", outs);
    end
    #2 reset = 1'b0;
  endtask

  task automatic test_clean_lock();
    bit ok;
    int d0, f0, e0;
    run_to_vfall(LOCK_FRAMES, ok);
    run_steps(4);
    n_cmp++;
    if (!ok || vif.locked !== 1'b0) begin
      n_bad++;
      $display("FAIL clean_early_lock got locked=%0b ok=%0b, required locked=0", vif.locked, ok);
    end
    run_to_vfall(LOCK_FRAMES + 1, ok);
    n_cmp++;
    if (!ok || vif.locked !== 1'b0) begin
      n_bad++;
      $display("FAIL clean_lock_at_edge got locked=%0b ok=%0b, required locked=0", vif.locked, ok);
    end
    run_steps(3);
    n_cmp++;
    if (vif.locked !== 1'b1) begin
      n_bad++;
      $display("FAIL clean_lock got locked=%0b, required 1", vif.locked);
    end
    n_cmp++;
    if (vif.htotal !== 11'(HT) || vif.hsync_width !== 11'(HSW) || vif.vtotal !== 11'(VT)) begin
      n_bad++;
      $display("FAIL clean_measure got htotal=%0d hsw=%0d vtotal=%0d, required %0d %0d %0d",
               vif.htotal, vif.hsync_width, vif.vtotal, HT, HSW, VT);
    end
    run_to_pos(0, 0, ok);
    d0 = de_cnt; f0 = fs_cnt; e0 = err_cnt;
    run_steps(2 * HT * VT);
    n_cmp++;
    if (de_cnt - d0 !== 2 * HLEN * VHEIGHT || fs_cnt - f0 !== 2) begin
      n_bad++;
      $display("FAIL clean_de_count got de=%0d fs=%0d, required de=%0d fs=2",
               de_cnt - d0, fs_cnt - f0, 2 * HLEN * VHEIGHT);
    end
    n_cmp++;
    if (exp_q.size() !== 0 || err_cnt !== e0) begin
      n_bad++;
      $display("FAIL clean_drain got pending=%0d errors=%0d, required 0 0",
               exp_q.size(), err_cnt - e0);
    end
  endtask

  task automatic test_line_glitch();
    bit ok;
    int e0;
    run_to_pos(0, 0, ok);
    e0 = err_cnt;
    glitch_gl = 5;
    run_to_pos(7, 0, ok);
    n_cmp++;
    if (err_cnt - e0 !== 1 || vif.locked !== 1'b0 || vif.de !== 1'b0) begin
      n_bad++;
      $display("FAIL glitch_unlock got errors=%0d locked=%0b de=%0b, required 1 0 0",
               err_cnt - e0, vif.locked, vif.de);
    end
    run_to_vfall(LOCK_FRAMES, ok);
    run_steps(4);
    n_cmp++;
    if (!ok || vif.locked !== 1'b0) begin
      n_bad++;
      $display("FAIL glitch_early_relock got locked=%0b ok=%0b, required locked=0", vif.locked, ok);
    end
    run_to_vfall(LOCK_FRAMES + 1, ok);
    run_steps(3);
    n_cmp++;
    if (!ok || vif.locked !== 1'b1 || vif.htotal !== 11'(HT)) begin
      n_bad++;
      $display("FAIL glitch_relock got locked=%0b htotal=%0d, required locked=1 htotal=%0d",
               vif.locked, vif.htotal, HT);
    end
  endtask

  task automatic test_frame_height();
    bit ok;
    int e0, guard;
    run_to_pos(0, 0, ok);
    e0 = err_cnt;
    tall_next = 1'b1;
    guard = 0;
    while (expect_lock && guard < 3 * HT * (VT + 1)) begin
      step();
      guard++;
    end
    run_steps(4);
    n_cmp++;
    if (expect_lock || vif.vtotal !== 11'(VT + 1) || err_cnt - e0 !== 1 || vif.locked !== 1'b0) begin
      n_bad++;
      $display("FAIL height_unlock got vtotal=%0d errors=%0d locked=%0b, required %0d 1 0",
               vif.vtotal, err_cnt - e0, vif.locked, VT + 1);
    end
    run_to_vfall(LOCK_FRAMES + 1, ok);
    run_steps(3);
    n_cmp++;
    if (!ok || vif.locked !== 1'b1 || vif.vtotal !== 11'(VT)) begin
      n_bad++;
      $display("FAIL height_relock got locked=%0b vtotal=%0d, required 1 %0d",
               vif.locked, vif.vtotal, VT);
    end
  endtask

  task automatic test_sync_loss();
    bit ok;
    int e0;
    run_to_pos(8, 0, ok);
    expect_lock = 1'b0;
    vfalls = 0;
    e0 = err_cnt;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      vif.Hsyncb = 1'b1;
      vif.Vsyncb = 1'b1;
    end
    n_cmp++;
    if (err_cnt - e0 !== 1 || vif.locked !== 1'b0 || vif.de !== 1'b0) begin
      n_bad++;
      $display("FAIL loss_unlock got errors=%0d locked=%0b de=%0b, required 1 0 0",
               err_cnt - e0, vif.locked, vif.de);
    end
    n_cmp++;
    if (dut.hcnt_q !== 11'd2047) begin
      n_bad++;
      $display("FAIL loss_saturate got hcnt=%0d, required 2047", dut.hcnt_q);
    end
    run_to_vfall(LOCK_FRAMES + 1, ok);
    run_steps(3);
    n_cmp++;
    if (!ok || vif.locked !== 1'b1) begin
      n_bad++;
      $display("FAIL loss_relock got locked=%0b ok=%0b, required locked=1", vif.locked, ok);
    end
  endtask

  task automatic test_reset_midline();
    bit ok;
    logic [59:0] outs;
    logic [32:0] meas;
    run_to_pos(6, 15, ok);
    #2 reset = 1'b1;
    #1;
    outs = {vif.x, vif.y, vif.htotal, vif.hsync_width, vif.vtotal,
            vif.de, vif.frame_start, vif.locked, vif.error};
    n_cmp++;
    if (outs !== 60'd0) begin
      n_bad++;
      $display("FAIL midline_reset_outputs got %h, required 0", outs);
    end
    exp_q.delete();
    expect_lock = 1'b0;
    vfalls = 0;
    run_steps(3);
    #2 reset = 1'b0;
    run_steps(8);
    meas = {vif.htotal, vif.hsync_width, vif.vtotal};
    n_cmp++;
    if (meas !== 33'd0) begin
      n_bad++;
      $display("FAIL midline_no_spurious got htotal=%0d hsw=%0d vtotal=%0d, required 0 0 0",
               vif.htotal, vif.hsync_width, vif.vtotal);
    end
    run_to_vfall(LOCK_FRAMES, ok);
    run_steps(4);
    n_cmp++;
    if (!ok || vif.locked !== 1'b0) begin
      n_bad++;
      $display("FAIL midline_early_lock got locked=%0b ok=%0b, required locked=0", vif.locked, ok);
    end
    run_to_vfall(LOCK_FRAMES + 1, ok);
    run_steps(3);
    n_cmp++;
    if (!ok || vif.locked !== 1'b1) begin
      n_bad++;
      $display("FAIL midline_relock got locked=%0b ok=%0b, required locked=1", vif.locked, ok);
    end
    run_to_pos(0, 0, ok);
    run_steps(HT * VT);
    n_cmp++;
    if (exp_q.size() !== 0 || vif.htotal !== 11'(HT)) begin
      n_bad++;
      $display("FAIL midline_drain got pending=%0d htotal=%0d, required 0 %0d",
               exp_q.size(), vif.htotal, HT);
    end
  endtask

  initial begin
    test_reset();
    test_clean_lock();
    test_line_glitch();
    test_frame_height();
    test_sync_loss();
    test_reset_midline();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
